qspi_flash_target: RTL and testbench
====================================

// Module: qspi_flash_target
// PURPOSE
//  Synthesizable QSPI flash responder: the device end of the bus driven by qspi_fsm.
//  Oversamples sclk/cs_n/io on the system clock, decodes opcode/address/dummy/data
//  phases, serves reads and page programs from an internal byte array and keeps a
//  status register. Used as a bench target and as an on-chip loopback flash.
// PARAMETERS
//  DEPTH      256  bytes of internal array (power of 2)
//  AW         8    array address bits = log2(DEPTH); bus address bits above AW ignored
//  DUMMY_FAST 8    dummy sclk cycles for 0x0B / 0x6B
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  reset       in   1   asynchronous, active-high
//  sclk        in   1   QSPI clock, mode 0 only (CPOL=0, CPHA=0)
//  cs_n        in   1   chip select, active low
//  io_in       in   4   sampled io[3:0]
//  io_out      out  4   driven io[3:0]
//  io_oe       out  4   per-lane output enable
//  cmd_lanes   in   2   opcode-phase width: 00 single (io0), 01 dual (io1:io0), 10/11 quad; static per frame
//  wel         out  1   write-enable latch (status bit 1)
//  cmd_strobe  out  1   1-clk pulse when 8th opcode bit is captured
//  last_opcode out  8   opcode of the most recent frame
// BEHAVIOUR
//  - Inputs pass through 2-flop synchronizers; sclk/cs_n edges detected on synchronized
//    copies. Requires sclk high and low >= 3 clk each; io sampled on sclk rise, driven on sclk fall.
//  - Reset: io_out=0, io_oe=0, wel=0, cmd_strobe=0, last_opcode=0, state=IDLE. Array not reset.
//  - States: IDLE -> CMD (cs_n fall) -> ADDR | STATUS | IGNORE (opcode decoded);
//    ADDR -> DUMMY | RD_DATA | WR_DATA; DUMMY -> RD_DATA. Any state -> IDLE on cs_n rise.
//  - CMD: shifts 1/2/4 bits per sclk rise MSB-first per cmd_lanes; after 8 bits: last_opcode
//    updated, cmd_strobe pulses.
//  - Opcodes: 06 WREN (wel<=1 at cs_n rise), 04 WRDI (wel<=0 at cs_n rise), 05 RDSR
//    (status {6'b0,wel,1'b0} repeats every 8 sclk on io1), 03 READ, 0B FAST READ
//    (DUMMY_FAST dummies), 02 PAGE PROGRAM. Addr 24 bits single-lane, MSB-first.
//    Unknown opcode -> IGNORE (io_oe=0) until cs_n rise.
//  - Reads: data on io1 MSB-first; first bit driven on sclk fall following the last
//    addr/dummy bit; io_oe[1]=1 from that fall until cs_n rise. io_oe=0 during dummies.
//  - Address increments per byte, wraps modulo DEPTH (DEPTH-1 -> 0).
//  - Program: each completed byte written to array only if wel=1 at frame start;
//    array byte <= old & new (NOR semantics). wel cleared at cs_n rise after any 02/32.
//    Partial byte at cs_n rise discarded; partial addr -> no access.
//  - cs_n rise mid-byte: io_oe=0 within 3 clk of cs_n rise, shift counters cleared.
//  - cs_n fall and sclk rise in same synchronized clk: cs_n handled first, bit sampled in CMD.
// CONFIGURATION
//  QSPI_TGT_QUAD_EN defined: adds 6B QUAD OUTPUT READ (single-lane addr, DUMMY_FAST
//    dummies, data nibble/sclk on io[3:0], high nibble first, io_oe=4'hF) and 32 QUAD
//    PAGE PROGRAM (data nibble/sclk on io_in[3:0]).
//  Undefined: 6B and 32 treated as unknown opcodes (IGNORE, io_oe stays 0).
// TESTING
//  clk 100 MHz, bench sclk 4 clk per half-period, array preloaded 8'hFF.
//  1 WREN 06 single, cs_n rise -> cmd_strobe 1 pulse, last_opcode=06, wel=1; RDSR 05 -> 8'h02 on io1.
//  2 WREN; 02 addr 000010 data A5,3C; READ 03 addr 000010 2 bytes -> A5,3C MSB-first; wel=0 after.
//  3 no WREN; 02 addr 000020 data 00; READ 000020 -> FF; wrap: READ 0000FF 2 bytes -> mem[FF],mem[00].
//  4 cmd_lanes=01, opcode AB -> last_opcode=AB after 4 sclk rises; IGNORE, io_oe=0 whole frame.
//  5 0B addr 000010, 8 dummies -> io_oe=0 during dummies, then A5; cs_n rise after 3 data bits ->
//    io_oe=0 within 3 clk, next frame decodes cleanly.
//  6 QSPI_TGT_QUAD_EN: WREN, 32 addr 000030 data 12; 6B addr 000030 -> io[3:0]=1 then 2;
//    macro undefined -> io_oe stays 0.

Source files
------------

// File: rtl/qspi_flash_target.sv
// Mode-0 QSPI flash device: byte array, WEL status, read/program; sclk-edge to io response ~3 clk, no backpressure.
// QSPI_TGT_QUAD_EN adds 6B quad output read and 32 quad page program.
module qspi_flash_target #(
    parameter int DEPTH      = 256,
    parameter int AW         = 8,
    parameter int DUMMY_FAST = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [3:0] io_in,
    output logic [3:0] io_out,
    output logic [3:0] io_oe,
    input  logic [1:0] cmd_lanes,
    output logic       wel,
    output logic       cmd_strobe,
    output logic [7:0] last_opcode
);
`ifdef QSPI_TGT_QUAD_EN
    localparam bit QUAD_EN = 1'b1;
`else
    localparam bit QUAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD_DATA, S_WR_DATA, S_STATUS, S_IGNORE
    } state_t;

    localparam logic [7:0]    SYNC_RST = 8'b0000_0010;
    localparam logic [7:0]    N_DUMMY  = 8'(DUMMY_FAST);
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    // {cmd_lanes, io_in, cs_n, sclk}; cs_n resets deasserted so no false frame start
    logic [7:0]    sync1_q, sync2_q;
    logic          sclk_p_q, cs_p_q;
    logic          sclk_s, cs_s;
    logic [3:0]    io_s;
    logic [1:0]    lanes_s;
    logic          sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [23:0]   sr_q, sr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          op_vld_q, op_vld_d;
    logic [3:0]    io_out_q, io_out_d;
    logic [3:0]    io_oe_q, io_oe_d;
    logic          wel_q, wel_d;
    logic          cmd_strobe_q, cmd_strobe_d;
    logic [7:0]    last_opcode_q, last_opcode_d;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_byte;
    logic [7:0]    status;
    logic          mem_we;
    logic [7:0]    mem_wdat;

    assign sclk_s    = sync2_q[0];
    assign cs_s      = sync2_q[1];
    assign io_s      = sync2_q[5:2];
    assign lanes_s   = sync2_q[7:6];
    assign sclk_rise = sclk_s & ~sclk_p_q;
    assign sclk_fall = ~sclk_s & sclk_p_q;
    assign cs_fall   = ~cs_s & cs_p_q;
    assign cs_rise   = cs_s & ~cs_p_q;
    assign rd_byte   = mem[addr_q];
    assign status    = {6'b0, wel_q, 1'b0};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        addr_d        = addr_q;
        op_vld_d      = op_vld_q;
        io_out_d      = io_out_q;
        io_oe_d       = io_oe_q;
        wel_d         = wel_q;
        cmd_strobe_d  = 1'b0;
        last_opcode_d = last_opcode_q;
        mem_we        = 1'b0;
        mem_wdat      = 8'h00;

        // Frame start is applied first so a coincident sclk rise lands in CMD
        if (cs_fall) begin
            state_d  = S_CMD;
            cnt_d    = 8'd0;
            sr_d     = 24'd0;
            op_vld_d = 1'b0;
            io_oe_d  = 4'h0;
            io_out_d = 4'h0;
        end

        case (state_d)
            S_CMD: if (sclk_rise) begin
                case (lanes_s)
                    2'b00: begin
                        sr_d  = {sr_d[22:0], io_s[0]};
                        cnt_d = cnt_d + 8'd1;
                    end
                    2'b01: begin
                        sr_d  = {sr_d[21:0], io_s[1:0]};
                        cnt_d = cnt_d + 8'd2;
                    end
                    default: begin
                        sr_d  = {sr_d[19:0], io_s};
                        cnt_d = cnt_d + 8'd4;
                    end
                endcase
                if (cnt_d == 8'd8) begin
                    last_opcode_d = sr_d[7:0];
                    cmd_strobe_d  = 1'b1;
                    op_vld_d      = 1'b1;
                    case (sr_d[7:0])
                        8'h03, 8'h0B, 8'h02: state_d = S_ADDR;
                        8'h05:               state_d = S_STATUS;
                        8'h6B, 8'h32:        state_d = QUAD_EN ? S_ADDR : S_IGNORE;
                        default:             state_d = S_IGNORE;
                    endcase
                    cnt_d = 8'd0;
                    sr_d  = 24'd0;
                end
            end
            S_ADDR: if (sclk_rise) begin
                sr_d  = {sr_d[22:0], io_s[0]};
                cnt_d = cnt_d + 8'd1;
                if (cnt_d == 8'd24) begin
                    addr_d = sr_d[AW-1:0];
                    cnt_d  = 8'd0;
                    sr_d   = 24'd0;
                    if (last_opcode_q == 8'h03)
                        state_d = S_RD_DATA;
                    else if (last_opcode_q == 8'h0B || last_opcode_q == 8'h6B)
                        state_d = (N_DUMMY == 8'd0) ? S_RD_DATA : S_DUMMY;
                    else
                        state_d = S_WR_DATA;
                end
            end
            S_DUMMY: if (sclk_rise) begin
                cnt_d = cnt_d + 8'd1;
                if (cnt_d == N_DUMMY) begin
                    cnt_d   = 8'd0;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: if (sclk_fall) begin
                if (QUAD_EN && last_opcode_q == 8'h6B) begin
                    io_oe_d  = 4'hF;
                    io_out_d = cnt_d[0] ? rd_byte[3:0] : rd_byte[7:4];
                    if (cnt_d[0]) begin
                        cnt_d  = 8'd0;
                        addr_d = addr_d + ADDR_ONE;
                    end else begin
                        cnt_d = cnt_d + 8'd1;
                    end
                end else begin
                    io_oe_d  = 4'b0010;
                    io_out_d = {2'b00, rd_byte[3'd7 - cnt_d[2:0]], 1'b0};
                    if (cnt_d == 8'd7) begin
                        cnt_d  = 8'd0;
                        addr_d = addr_d + ADDR_ONE;
                    end else begin
                        cnt_d = cnt_d + 8'd1;
                    end
                end
            end
            S_WR_DATA: if (sclk_rise) begin
                if (QUAD_EN && last_opcode_q == 8'h32) begin
                    sr_d  = {sr_d[19:0], io_s};
                    cnt_d = cnt_d + 8'd4;
                end else begin
                    sr_d  = {sr_d[22:0], io_s[0]};
                    cnt_d = cnt_d + 8'd1;
                end
                if (cnt_d == 8'd8) begin
                    // NOR program: bits can only be cleared
                    mem_we   = wel_q;
                    mem_wdat = rd_byte & sr_d[7:0];
                    addr_d   = addr_d + ADDR_ONE;
                    cnt_d    = 8'd0;
                    sr_d     = 24'd0;
                end
            end
            S_STATUS: if (sclk_fall) begin
                io_oe_d  = 4'b0010;
                io_out_d = {2'b00, status[3'd7 - cnt_d[2:0]], 1'b0};
                cnt_d    = {5'd0, cnt_d[2:0] + 3'd1};
            end
            default: ;
        endcase

        if (cs_rise) begin
            if (op_vld_d) begin
                case (last_opcode_d)
                    8'h06:               wel_d = 1'b1;
                    8'h04, 8'h02, 8'h32: wel_d = 1'b0;
                    default: ;
                endcase
            end
            state_d  = S_IDLE;
            cnt_d    = 8'd0;
            sr_d     = 24'd0;
            op_vld_d = 1'b0;
            io_oe_d  = 4'h0;
            io_out_d = 4'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= SYNC_RST;
            sync2_q       <= SYNC_RST;
            sclk_p_q      <= 1'b0;
            cs_p_q        <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            sr_q          <= 24'd0;
            addr_q        <= '0;
            op_vld_q      <= 1'b0;
            io_out_q      <= 4'h0;
            io_oe_q       <= 4'h0;
            wel_q         <= 1'b0;
            cmd_strobe_q  <= 1'b0;
            last_opcode_q <= 8'h00;
        end else begin
            sync1_q       <= {cmd_lanes, io_in, cs_n, sclk};
            sync2_q       <= sync1_q;
            sclk_p_q      <= sclk_s;
            cs_p_q        <= cs_s;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            addr_q        <= addr_d;
            op_vld_q      <= op_vld_d;
            io_out_q      <= io_out_d;
            io_oe_q       <= io_oe_d;
            wel_q         <= wel_d;
            cmd_strobe_q  <= cmd_strobe_d;
            last_opcode_q <= last_opcode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr_q] <= mem_wdat;
    end

    assign io_out      = io_out_q;
    assign io_oe       = io_oe_q;
    assign wel         = wel_q;
    assign cmd_strobe  = cmd_strobe_q;
    assign last_opcode = last_opcode_q;

endmodule

// File: tb/tb_qspi_flash_target.sv
// Bench for qspi_flash_target: acts as a mode-0 QSPI host and compares against a byte-array flash model.
module tb_qspi_flash_target;
    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       cs_n;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic [3:0] io_oe;
    logic [1:0] cmd_lanes;
    logic       wel;
    logic       cmd_strobe;
    logic [7:0] last_opcode;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    logic [3:0] oe_acc;
    logic [7:0] mem_m [256];
    logic       wel_m;

    qspi_flash_target dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .io_in(io_in),
        .io_out(io_out), .io_oe(io_oe), .cmd_lanes(cmd_lanes), .wel(wel),
        .cmd_strobe(cmd_strobe), .last_opcode(last_opcode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_strobe === 1'b1) strobe_cnt++;
        oe_acc = oe_acc | io_oe;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk period: low half (io set, outputs sampled at its end), then high half
    task automatic sclk_cycle(input logic [3:0] d, output logic [3:0] so, output logic [3:0] soe);
        io_in = d;
        wait_clk(4);
        so  = io_out;
        soe = io_oe;
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame_end();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_op(input logic [7:0] op);
        logic [3:0] so, soe;
        case (cmd_lanes)
            2'b00: for (int i = 7; i >= 0; i--) sclk_cycle({3'b0, op[i]}, so, soe);
            2'b01: for (int i = 3; i >= 0; i--) sclk_cycle({2'b0, op[2*i+1], op[2*i]}, so, soe);
            default: begin
                sclk_cycle(op[7:4], so, soe);
                sclk_cycle(op[3:0], so, soe);
            end
        endcase
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [3:0] so, soe;
        for (int i = 23; i >= 0; i--) sclk_cycle({3'b0, a[i]}, so, soe);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] so, soe;
        for (int i = 7; i >= 0; i--) sclk_cycle({3'b0, b[i]}, so, soe);
    endtask

    task automatic dummies(input int n);
        logic [3:0] so, soe;
        for (int i = 0; i < n; i++) sclk_cycle(4'h0, so, soe);
    endtask

    task automatic read_bits(input int n, output logic [7:0] b, output logic oe_ok);
        logic [3:0] so, soe;
        b = 8'h00;
        oe_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            sclk_cycle(4'h0, so, soe);
            b = {b[6:0], so[1]};
            if (soe !== 4'b0010) oe_ok = 1'b0;
        end
    endtask

    task automatic wren_frame();
        frame_start();
        send_op(8'h06);
        frame_end();
        wel_m = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++; if (io_out !== 4'h0) begin n_fail++; $display("FAIL reset_io_out: got %h expected 0", io_out); end
        n_checks++; if (io_oe !== 4'h0) begin n_fail++; $display("FAIL reset_io_oe: got %h expected 0", io_oe); end
        n_checks++; if (wel !== 1'b0) begin n_fail++; $display("FAIL reset_wel: got %b expected 0", wel); end
        n_checks++; if (cmd_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_strobe: got %b expected 0", cmd_strobe); end
        n_checks++; if (last_opcode !== 8'h00) begin n_fail++; $display("FAIL reset_last_opcode: got %h expected 00", last_opcode); end
    endtask

    task automatic test_wren_rdsr();
        int s0;
        logic [7:0] b;
        logic ok;
        s0 = strobe_cnt;
        wren_frame();
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL wren_strobe_count: got %0d expected 1", strobe_cnt - s0); end
        n_checks++; if (last_opcode !== 8'h06) begin n_fail++; $display("FAIL wren_last_opcode: got %h expected 06", last_opcode); end
        n_checks++; if (wel !== wel_m) begin n_fail++; $display("FAIL wren_wel: got %b expected %b", wel, wel_m); end
        frame_start();
        send_op(8'h05);
        for (int k = 0; k < 2; k++) begin
            read_bits(8, b, ok);
            n_checks++; if (b !== {6'b0, wel_m, 1'b0}) begin n_fail++; $display("FAIL rdsr_byte%0d: got %h expected %h", k, b, {6'b0, wel_m, 1'b0}); end
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rdsr_oe%0d: got %b expected 1", k, ok); end
        end
        frame_end();
    endtask

    task automatic program_frame(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
        logic [7:0] ix;
        frame_start();
        send_op(8'h02);
        send_addr(a);
        for (int k = 0; k < n; k++) begin
            send_byte(k == 0 ? d0 : d1);
            ix = a[7:0] + 8'(k);
            if (wel_m) mem_m[ix] = mem_m[ix] & (k == 0 ? d0 : d1);
        end
        frame_end();
        wel_m = 1'b0;
    endtask

    task automatic read_check(input logic [23:0] a, input int n, input logic [7:0] opc, input string nm);
        logic [7:0] b, ix;
        logic ok;
        frame_start();
        send_op(opc);
        send_addr(a);
        if (opc == 8'h0B) dummies(8);
        for (int k = 0; k < n; k++) begin
            ix = a[7:0] + 8'(k);
            read_bits(8, b, ok);
            n_checks++; if (b !== mem_m[ix]) begin n_fail++; $display("FAIL %s_data%0d: got %h expected %h", nm, k, b, mem_m[ix]); end
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_oe%0d: got %b expected 1", nm, k, ok); end
        end
        frame_end();
    endtask

    task automatic test_program_read();
        wren_frame();
        program_frame(24'h000010, 8'hA5, 8'h3C, 2);
        n_checks++; if (wel !== 1'b0) begin n_fail++; $display("FAIL pp_wel_cleared: got %b expected 0", wel); end
        read_check(24'h000010, 2, 8'h03, "pp_read");
    endtask

    task automatic test_no_wren_wrap();
        program_frame(24'h000020, 8'h00, 8'h00, 1);
        read_check(24'h000020, 1, 8'h03, "nowren");
        read_check(24'h0000FF, 2, 8'h03, "wrap");
    endtask

    task automatic test_dual_ignore();
        logic [3:0] so, soe;
        cmd_lanes = 2'b01;
        oe_acc = 4'h0;
        frame_start();
        send_op(8'hAB);
        n_checks++; if (last_opcode !== 8'hAB) begin n_fail++; $display("FAIL dual_last_opcode: got %h expected AB", last_opcode); end
        for (int i = 0; i < 10; i++) sclk_cycle(4'(i), so, soe);
        frame_end();
        n_checks++; if (oe_acc !== 4'h0) begin n_fail++; $display("FAIL ignore_oe: got %h expected 0", oe_acc); end
        cmd_lanes = 2'b00;
    endtask

    task automatic test_fast_read_abort();
        logic [7:0] b;
        logic ok;
        frame_start();
        send_op(8'h0B);
        send_addr(24'h000010);
        oe_acc = 4'h0;
        dummies(8);
        n_checks++; if (oe_acc !== 4'h0) begin n_fail++; $display("FAIL fast_dummy_oe: got %h expected 0", oe_acc); end
        read_bits(8, b, ok);
        n_checks++; if (b !== mem_m[8'h10]) begin n_fail++; $display("FAIL fast_data: got %h expected %h", b, mem_m[8'h10]); end
        read_bits(3, b, ok);
        n_checks++; if (b[2:0] !== mem_m[8'h11][7:5]) begin n_fail++; $display("FAIL fast_partial: got %b expected %b", b[2:0], mem_m[8'h11][7:5]); end
        wait_clk(2);
        cs_n = 1'b1;
        wait_clk(3);
        n_checks++; if (io_oe !== 4'h0) begin n_fail++; $display("FAIL abort_oe: got %h expected 0", io_oe); end
        wait_clk(6);
        read_check(24'h000011, 1, 8'h03, "after_abort");
        n_checks++; if (last_opcode !== 8'h03) begin n_fail++; $display("FAIL after_abort_opcode: got %h expected 03", last_opcode); end
    endtask

    task automatic test_quad();
        logic [3:0] so, soe;
`ifdef QSPI_TGT_QUAD_EN
        wren_frame();
        frame_start();
        send_op(8'h32);
        send_addr(24'h000030);
        sclk_cycle(4'h1, so, soe);
        sclk_cycle(4'h2, so, soe);
        frame_end();
        mem_m[8'h30] = mem_m[8'h30] & 8'h12;
        wel_m = 1'b0;
        frame_start();
        send_op(8'h6B);
        send_addr(24'h000030);
        dummies(8);
        sclk_cycle(4'h0, so, soe);
        n_checks++; if (so !== mem_m[8'h30][7:4] || soe !== 4'hF) begin n_fail++; $display("FAIL quad_hi: got %h oe %h expected %h oe F", so, soe, mem_m[8'h30][7:4]); end
        sclk_cycle(4'h0, so, soe);
        n_checks++; if (so !== mem_m[8'h30][3:0] || soe !== 4'hF) begin n_fail++; $display("FAIL quad_lo: got %h oe %h expected %h oe F", so, soe, mem_m[8'h30][3:0]); end
        frame_end();
`else
        oe_acc = 4'h0;
        frame_start();
        send_op(8'h32);
        send_addr(24'h000030);
        sclk_cycle(4'h1, so, soe);
        sclk_cycle(4'h2, so, soe);
        frame_end();
        n_checks++; if (last_opcode !== 8'h32) begin n_fail++; $display("FAIL noquad_opcode: got %h expected 32", last_opcode); end
        frame_start();
        send_op(8'h6B);
        send_addr(24'h000030);
        dummies(12);
        frame_end();
        n_checks++; if (oe_acc !== 4'h0) begin n_fail++; $display("FAIL noquad_oe: got %h expected 0", oe_acc); end
        wel_m = 1'b0;
`endif
        read_check(24'h000030, 1, 8'h03, "quad_mem");
    endtask

    task automatic test_random();
        logic [23:0] a;
        logic [7:0] d0, d1;
        int n;
        for (int it = 0; it < 6; it++) begin
            a  = 24'($urandom);
            n  = $urandom_range(1, 2);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            cmd_lanes = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) wren_frame();
            program_frame(a, d0, d1, n);
            n_checks++; if (wel !== wel_m) begin n_fail++; $display("FAIL rand_wel%0d: got %b expected %b", it, wel, wel_m); end
            read_check(a, n, ($urandom_range(0, 1) == 1) ? 8'h0B : 8'h03, "rand");
        end
        cmd_lanes = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        io_in = 4'h0;
        cmd_lanes = 2'b00;
        oe_acc = 4'h0;
        wel_m = 1'b0;
        for (int i = 0; i < 256; i++) begin
            dut.mem[i] <= 8'hFF;
            mem_m[i] = 8'hFF;
        end
        wait_clk(5);
        test_reset();
        reset = 1'b0;
        wait_clk(5);
        test_wren_rdsr();
        test_program_read();
        test_no_wren_wrap();
        test_dual_ignore();
        test_fast_read_abort();
        test_quad();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
